// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce
// Brief   : Synchronises and debounces one pushbutton pin; emits level,
//           press/release pulses and long-press detection.
// Revision: 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int unsigned CLK_HZ        = 25_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1500,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic held_long_o
);

  localparam int unsigned DB_MAX = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LP_MAX = CLK_HZ / 1000 * LONG_PRESS_MS;
  localparam int unsigned DB_W   = $clog2(DB_MAX);
  localparam int unsigned LP_W   = $clog2(LP_MAX);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_MAX - 1);
  localparam logic [LP_W-1:0] LP_LAST  = LP_W'(LP_MAX - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [LP_W-1:0] LP_ONE   = LP_W'(1);
  localparam logic            PIN_IDLE = ACTIVE_LOW;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_PRESSED      = 3'd2;
  localparam logic [2:0] ST_LONG_HELD    = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [2:0]      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [LP_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            src_long_q, src_long_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_press_q, long_press_d;
  logic            held_long_q, held_long_d;
  logic            pressed_s;

  assign sync1_d   = btn_i;
  assign sync2_d   = sync1_q;
  assign pressed_s = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q      <= PIN_IDLE;
      sync2_q      <= PIN_IDLE;
      state_q      <= ST_IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      src_long_q   <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      held_long_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      src_long_q   <= src_long_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
      held_long_q  <= held_long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    src_long_d = src_long_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      ST_PRESSED: begin
        // A release sampled on the terminal hold count wins over the long press.
        if (!pressed_s) begin
          state_d    = ST_RELEASE_WAIT;
          db_cnt_d   = '0;
          src_long_d = 1'b0;
        end else if (hold_cnt_q == LP_LAST) begin
          state_d = ST_LONG_HELD;
        end else begin
          hold_cnt_d = hold_cnt_q + LP_ONE;
        end
      end
      ST_LONG_HELD: begin
        if (!pressed_s) begin
          state_d    = ST_RELEASE_WAIT;
          db_cnt_d   = '0;
          src_long_d = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = src_long_q ? ST_LONG_HELD : ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs follow the accepted transitions and are registered alongside the state.
  always_comb begin
    level_d      = level_q;
    held_long_d  = held_long_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = 1'b0;
    if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
      press_d = 1'b1;
      level_d = 1'b1;
    end
    if ((state_q == ST_PRESSED) && (state_d == ST_LONG_HELD)) begin
      long_press_d = 1'b1;
      held_long_d  = 1'b1;
    end
    if ((state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE)) begin
      release_d   = 1'b1;
      level_d     = 1'b0;
      held_long_d = 1'b0;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_press_q;
  assign held_long_o  = held_long_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_debounce
// Brief   : Directed self-checking bench for button_debounce (DB_MAX=4, LP_MAX=20).
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int DB_MAX = 4;
  localparam int LP_MAX = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b1;
  logic level, press, rel, long_p, held_long;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_press  = 0;
  int n_rel    = 0;
  int n_long   = 0;

  button_debounce #(
    .CLK_HZ       (1000),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(20),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .btn_i       (btn),
    .level_o     (level),
    .press_o     (press),
    .release_o   (rel),
    .long_press_o(long_p),
    .held_long_o (held_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: a change is accepted after DB_MAX+1 consecutive samples disagreeing
  // with the accepted level; long press after LP_MAX samples of steady hold.
  typedef struct packed {
    logic        acc;
    logic        lng;
    logic        pr;
    logic        rl;
    logic        lp;
    logic [31:0] run;
    logic [31:0] hold;
  } model_t;

  function automatic model_t step(input model_t s, input logic p);
    model_t n = s;
    n.pr = 1'b0;
    n.rl = 1'b0;
    n.lp = 1'b0;
    if (!s.acc) begin
      n.run = p ? s.run + 1 : 0;
      if (n.run == DB_MAX + 1) begin
        n.acc  = 1'b1;
        n.pr   = 1'b1;
        n.run  = 0;
        n.hold = 0;
      end
    end else if (!p) begin
      n.run = s.run + 1;
      if (n.run == DB_MAX + 1) begin
        n.acc = 1'b0;
        n.lng = 1'b0;
        n.rl  = 1'b1;
        n.run = 0;
      end
    end else begin
      if (s.run == 0 && !s.lng) begin
        n.hold = s.hold + 1;
        if (n.hold == LP_MAX) begin
          n.lng = 1'b1;
          n.lp  = 1'b1;
        end
      end
      n.run = 0;
    end
    return n;
  endfunction

  logic   m_b1, m_b2;
  model_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b1 <= 1'b1;
      m_b2 <= 1'b1;
      m    <= '0;
    end else begin
      m_b1 <= btn;
      m_b2 <= m_b1;
      m    <= step(m, ~m_b2);
    end
  end

  always @(negedge clk) begin
    check("level",      int'(level),     int'(m.acc));
    check("press",      int'(press),     int'(m.pr));
    check("release",    int'(rel),       int'(m.rl));
    check("long_press", int'(long_p),    int'(m.lp));
    check("held_long",  int'(held_long), int'(m.lng));
    if (press)  n_press++;
    if (rel)    n_rel++;
    if (long_p) n_long++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // sel: 0 press, 1 release, 2 long press. Returns the cycle the pulse is seen.
  task automatic wait_for(input int sel, input int budget, input string name, output int at);
    bit seen = 1'b0;
    int k    = 0;
    at = -1;
    while (k < budget && !seen) begin
      @(negedge clk);
      k++;
      case (sel)
        0:       seen = press;
        1:       seen = rel;
        default: seen = long_p;
      endcase
      if (seen) at = cyc;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles expected a pulse", name, budget);
    end
  endtask

  initial begin
    int t_e, t_p, t_l, t_r;

    // 1: reset, idle pin
    rst_n = 1'b0;
    btn   = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("t1_press_cnt", n_press, 0);
    check("t1_level", int'(level), 0);
    check("t1_rel_cnt", n_rel + n_long, 0);

    // 2: clean press
    btn = 1'b0;
    t_e = cyc;
    wait_for(0, 30, "t2_press", t_p);
    check("t2_press_delay", t_p - t_e, 7);
    check("t2_level", int'(level), 1);

    // 4: long hold then release
    wait_for(2, 40, "t4_long", t_l);
    check("t4_long_delay", t_l - t_p, 20);
    check("t4_held_long", int'(held_long), 1);
    tick(10);
    btn = 1'b1;
    t_e = cyc;
    wait_for(1, 30, "t4_release", t_r);
    check("t4_release_delay", t_r - t_e, 7);
    check("t4_level_drop", int'(level), 0);
    check("t4_held_long_drop", int'(held_long), 0);
    check("t4_long_cnt", n_long, 1);

    // 3: short glitch rejected
    tick(5);
    btn = 1'b0;
    tick(3);
    btn = 1'b1;
    tick(20);
    check("t3_press_cnt", n_press, 1);
    check("t3_level", int'(level), 0);

    // 5: bounce while pressed
    btn = 1'b0;
    wait_for(0, 30, "t5_press", t_p);
    tick(3);
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(1);
    btn = 1'b1;
    t_e = cyc;
    wait_for(1, 30, "t5_release", t_r);
    check("t5_release_delay", t_r - t_e, 7);
    tick(10);
    check("t5_press_cnt", n_press, 2);
    check("t5_rel_cnt", n_rel, 2);
    check("t5_long_cnt", n_long, 1);

    // 6: reset in the middle of a press
    btn = 1'b0;
    wait_for(0, 30, "t6_press", t_p);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("t6_level_rst", int'(level), 0);
    check("t6_outs_rst", int'(press) + int'(rel) + int'(long_p) + int'(held_long), 0);
    tick(3);
    rst_n = 1'b1;
    t_e = cyc;
    wait_for(0, 30, "t6_repress", t_p);
    check("t6_press_delay", t_p - t_e, 7);
    check("t6_rel_cnt", n_rel, 2);
    btn = 1'b1;
    tick(20);
    check("t6_level_end", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
